// File: rtl/wb_flash_arbiter_pkg.sv
// Shared definitions for the flash-side Wishbone arbiter.
// State encodings and default watchdog limit.
package wb_flash_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT0  = 2'd1,
    ARB_GRANT1  = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/wb_watchdog.sv
// Grant watchdog: counts cycles without slave response.
// Saturating counter; expire flags the last allowed cycle.
module wb_watchdog
  import wb_flash_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;

  // count enabled cycles, clear wins, hold at MAX
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // a response this cycle suppresses expiry
  always_comb begin
    expire_o = en_i & ~clr_i & (r_cnt >= LAST);
  end

endmodule

// File: rtl/wb_flash_arbiter.sv
// Two-master pipelined Wishbone arbiter for the flash port.
// Round-robin grant with a watchdog that frees a hung bus.
module wb_flash_arbiter
  import wb_flash_arbiter_pkg::*;
#(
  parameter int ADDRBITS       = 26,
  parameter int DATABITS       = 16,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [ADDRBITS-1:0] m0_adr_i,
  input  logic [DATABITS-1:0] m0_dat_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic                m0_stall_o,
  output logic [DATABITS-1:0] m0_dat_o,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [ADDRBITS-1:0] m1_adr_i,
  input  logic [DATABITS-1:0] m1_dat_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic                m1_stall_o,
  output logic [DATABITS-1:0] m1_dat_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [ADDRBITS-1:0] s_adr_o,
  output logic [DATABITS-1:0] s_dat_o,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  input  logic                s_stall_i,
  input  logic [DATABITS-1:0] s_dat_i,
  output logic [1:0]          owner_o,
  output logic                timeout_o
);

  arb_state_e r_state;
  logic       r_last_m1;
  logic       r_rel_m1;
  logic       r_timeout;
  logic [1:0] r_owner;

  logic w_g0;
  logic w_g1;
  logic w_grant;
  logic w_wd_clr;
  logic w_expire;

  assign w_g0     = (r_state == ARB_GRANT0);
  assign w_g1     = (r_state == ARB_GRANT1);
  assign w_grant  = w_g0 | w_g1;
  assign w_wd_clr = ~w_grant | s_ack_i | s_err_i;

  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (w_wd_clr),
    .en_i     (w_grant),
    .expire_o (w_expire)
  );

  // arbitration FSM with registered owner/timeout flags
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state   <= ARB_IDLE;
      r_last_m1 <= 1'b1;
      r_rel_m1  <= 1'b0;
      r_timeout <= 1'b0;
      r_owner   <= 2'b00;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || r_last_m1)) begin
            r_state   <= ARB_GRANT0;
            r_last_m1 <= 1'b0;
            r_owner   <= 2'b01;
          end else if (m1_cyc_i) begin
            r_state   <= ARB_GRANT1;
            r_last_m1 <= 1'b1;
            r_owner   <= 2'b10;
          end
        end
        ARB_GRANT0: begin
          if (!m0_cyc_i) begin
            r_state <= ARB_IDLE;
            r_owner <= 2'b00;
          end else if (w_expire) begin
            r_state   <= ARB_RELEASE;
            r_owner   <= 2'b00;
            r_rel_m1  <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        ARB_GRANT1: begin
          if (!m1_cyc_i) begin
            r_state <= ARB_IDLE;
            r_owner <= 2'b00;
          end else if (w_expire) begin
            r_state   <= ARB_RELEASE;
            r_owner   <= 2'b00;
            r_rel_m1  <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        ARB_RELEASE: begin
          if (r_rel_m1 ? !m1_cyc_i : !m0_cyc_i) begin
            r_state <= ARB_IDLE;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_owner <= 2'b00;
        end
      endcase
    end
  end

  // bus pass-through for the owner, parked values otherwise
  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    m0_ack_o   = 1'b0;
    m0_err_o   = r_timeout & ~r_rel_m1;
    m0_stall_o = 1'b1;
    m0_dat_o   = '0;
    m1_ack_o   = 1'b0;
    m1_err_o   = r_timeout & r_rel_m1;
    m1_stall_o = 1'b1;
    m1_dat_o   = '0;
    unique case (1'b1)
      w_g0: begin
        s_cyc_o    = m0_cyc_i;
        s_stb_o    = m0_stb_i;
        s_we_o     = m0_we_i;
        s_adr_o    = m0_adr_i;
        s_dat_o    = m0_dat_i;
        m0_ack_o   = s_ack_i;
        m0_err_o   = s_err_i;
        m0_stall_o = s_stall_i;
        m0_dat_o   = s_dat_i;
      end
      w_g1: begin
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_stb_i;
        s_we_o     = m1_we_i;
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        m1_ack_o   = s_ack_i;
        m1_err_o   = s_err_i;
        m1_stall_o = s_stall_i;
        m1_dat_o   = s_dat_i;
      end
      default: ;
    endcase
  end

  assign owner_o   = r_owner;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_wb_flash_arbiter.sv
// Directed bench for wb_flash_arbiter.
// Watchdog limit shortened to 8 cycles.
module tb_wb_flash_arbiter;

  localparam int AW = 26;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk;
  logic          rst_n;
  logic          m0_cyc, m0_stb, m0_we;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_wdat;
  logic          m0_ack, m0_err, m0_stall;
  logic [DW-1:0] m0_rdat;
  logic          m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_wdat;
  logic          m1_ack, m1_err, m1_stall;
  logic [DW-1:0] m1_rdat;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat;
  logic          s_ack, s_err, s_stall;
  logic [DW-1:0] s_rdat;
  logic [1:0]    owner;
  logic          tmo;

  int n_cmp = 0;
  int n_bad = 0;

  wb_flash_arbiter #(
    .ADDRBITS(AW), .DATABITS(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_stall_o(m0_stall), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_stall_o(m1_stall), .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_wdat),
    .s_ack_i(s_ack), .s_err_i(s_err),
    .s_stall_i(s_stall), .s_dat_i(s_rdat),
    .owner_o(owner), .timeout_o(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m0_adr = '0; m0_wdat = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    m1_adr = '0; m1_wdat = '0;
    s_ack = 0; s_err = 0; s_stall = 0;
    s_rdat = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    rst_n = 1;
    step();
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_own"}, 32'(owner), 32'h0);
    chk({tag, "_scyc"}, 32'(s_cyc), 32'h0);
    chk({tag, "_sadr"}, 32'(s_adr), 32'h0);
    chk({tag, "_st0"}, 32'(m0_stall), 32'h1);
    chk({tag, "_st1"}, 32'(m1_stall), 32'h1);
    chk({tag, "_ack1"}, 32'(m1_ack), 32'h0);
    chk({tag, "_dat1"}, 32'(m1_rdat), 32'h0);
    chk({tag, "_tmo"}, 32'(tmo), 32'h0);
  endtask

  initial begin
    idle_in();
    rst_n = 0;
    #2;
    chk_rst("rst");
    step();
    step();
    rst_n = 1;
    step();

    // single master 0 read
    m0_cyc = 1; m0_stb = 1; m0_adr = 26'h123456;
    smp();
    chk("rd_idle_stall", 32'(m0_stall), 32'h1);
    chk("rd_idle_scyc", 32'(s_cyc), 32'h0);
    step();
    smp();
    chk("rd_own", 32'(owner), 32'h1);
    chk("rd_stall0", 32'(m0_stall), 32'h0);
    chk("rd_scyc", 32'(s_cyc), 32'h1);
    chk("rd_sadr", 32'(s_adr), 32'h123456);
    chk("rd_st1", 32'(m1_stall), 32'h1);
    step();
    m0_stb = 0;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("rd_noack", 32'(m0_ack), 32'h0);
      chk("rd_st1w", 32'(m1_stall), 32'h1);
      step();
    end
    s_ack = 1; s_rdat = 16'hBEEF;
    smp();
    chk("rd_ack", 32'(m0_ack), 32'h1);
    chk("rd_dat", 32'(m0_rdat), 32'hBEEF);
    chk("rd_ack1", 32'(m1_ack), 32'h0);
    chk("rd_dat1", 32'(m1_rdat), 32'h0);
    step();
    s_ack = 0; s_rdat = '0; m0_cyc = 0;
    smp();
    chk("rd_own_hold", 32'(owner), 32'h1);
    step();
    smp();
    chk("rd_own_idle", 32'(owner), 32'h0);
    step();

    // simultaneous requests after reset
    do_reset();
    m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m1_stb = 1;
    step();
    smp();
    chk("tie_own0", 32'(owner), 32'h1);
    chk("tie_st1", 32'(m1_stall), 32'h1);
    step();
    m0_cyc = 0; m0_stb = 0;
    step();
    smp();
    chk("tie_idle", 32'(owner), 32'h0);
    chk("tie_idle_st1", 32'(m1_stall), 32'h1);
    m0_cyc = 1; m0_stb = 1;
    step();
    smp();
    chk("tie2_own1", 32'(owner), 32'h2);
    chk("tie2_st1", 32'(m1_stall), 32'h0);
    chk("tie2_st0", 32'(m0_stall), 32'h1);
    step();
    m1_cyc = 0; m1_stb = 0;
    step();
    step();
    smp();
    chk("tie2_own0", 32'(owner), 32'h1);
    step();
    m0_cyc = 0; m0_stb = 0;
    step();
    step();

    // master 1 write, master 0 arrives mid-cycle
    m1_cyc = 1; m1_stb = 1; m1_we = 1;
    m1_adr = 26'h3ABCDE; m1_wdat = 16'h00F0;
    step();
    m0_cyc = 1; m0_stb = 1; s_stall = 1;
    smp();
    chk("wr_own", 32'(owner), 32'h2);
    chk("wr_we", 32'(s_we), 32'h1);
    chk("wr_sdat", 32'(s_wdat), 32'h00F0);
    chk("wr_sadr", 32'(s_adr), 32'h3ABCDE);
    chk("wr_st1_hi", 32'(m1_stall), 32'h1);
    chk("wr_st0a", 32'(m0_stall), 32'h1);
    step();
    s_stall = 0;
    smp();
    chk("wr_st1_lo", 32'(m1_stall), 32'h0);
    chk("wr_st0b", 32'(m0_stall), 32'h1);
    step();
    m1_stb = 0; s_ack = 1;
    smp();
    chk("wr_ack1", 32'(m1_ack), 32'h1);
    chk("wr_ack0", 32'(m0_ack), 32'h0);
    chk("wr_st0c", 32'(m0_stall), 32'h1);
    step();
    s_ack = 0; m1_cyc = 0; m1_we = 0;
    m1_adr = '0; m1_wdat = '0;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("wr_st0d", 32'(m0_stall), 32'h1);
      step();
    end
    smp();
    chk("wr_own0", 32'(owner), 32'h1);
    chk("wr_st0e", 32'(m0_stall), 32'h0);
    step();
    m0_cyc = 0; m0_stb = 0;
    step();
    step();

    // hung slave: watchdog fires
    m0_cyc = 1; m0_stb = 1; m0_adr = 26'h000ABC;
    step();
    for (int k = 1; k <= TO; k++) begin
      smp();
      chk("to_own", 32'(owner), 32'h1);
      chk("to_scyc", 32'(s_cyc), 32'h1);
      chk("to_err_early", 32'(m0_err), 32'h0);
      chk("to_tmo_early", 32'(tmo), 32'h0);
      step();
    end
    smp();
    chk("to_err", 32'(m0_err), 32'h1);
    chk("to_tmo", 32'(tmo), 32'h1);
    chk("to_err1", 32'(m1_err), 32'h0);
    chk("to_rel_scyc", 32'(s_cyc), 32'h0);
    chk("to_rel_st0", 32'(m0_stall), 32'h1);
    chk("to_rel_own", 32'(owner), 32'h0);
    step();
    s_ack = 1; m1_cyc = 1; m1_stb = 1;
    smp();
    chk("to_late_ack", 32'(m0_ack), 32'h0);
    chk("to_err_once", 32'(m0_err), 32'h0);
    chk("to_tmo_once", 32'(tmo), 32'h0);
    chk("to_rel_hold", 32'(s_cyc), 32'h0);
    step();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    smp();
    chk("to_rel_own2", 32'(owner), 32'h0);
    step();
    smp();
    chk("to_idle", 32'(owner), 32'h0);
    step();
    smp();
    chk("to_next_m1", 32'(owner), 32'h2);
    step();
    m1_cyc = 0; m1_stb = 0;
    step();
    step();

    // ack on the expiry cycle, then cyc drop on expiry
    m0_cyc = 1; m0_stb = 1;
    step();
    for (int k = 1; k < TO; k++) step();
    s_ack = 1; s_rdat = 16'h1234;
    smp();
    chk("co_ack", 32'(m0_ack), 32'h1);
    chk("co_dat", 32'(m0_rdat), 32'h1234);
    step();
    s_ack = 0; s_rdat = '0;
    smp();
    chk("co_tmo", 32'(tmo), 32'h0);
    chk("co_err", 32'(m0_err), 32'h0);
    chk("co_own", 32'(owner), 32'h1);
    for (int k = 1; k < TO; k++) step();
    m0_cyc = 0; m0_stb = 0;
    step();
    smp();
    chk("dr_tmo", 32'(tmo), 32'h0);
    chk("dr_err", 32'(m0_err), 32'h0);
    chk("dr_own", 32'(owner), 32'h0);
    step();

    // async reset mid-transfer in GRANT1
    m1_cyc = 1; m1_stb = 1; m1_adr = 26'h2000001;
    step();
    s_ack = 1; s_rdat = 16'h5A5A;
    smp();
    chk("ar_own", 32'(owner), 32'h2);
    chk("ar_ack", 32'(m1_ack), 32'h1);
    #2;
    rst_n = 0;
    #1;
    chk_rst("ar");
    step();
    idle_in();
    rst_n = 1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_flash_arbiter.md
# wb_flash_arbiter

Two-master Wishbone (pipelined) arbiter with a per-grant watchdog, sharing the single flash-side Wishbone slave port between the QSPI command FSM (master 0) and the on-chip scan/VT sequencer (master 1). It sits between those masters and the flash controller. It is fair round-robin with master 0 winning ties from reset. It guarantees that a hung slave cannot lock the bus: it errors the owner and releases the bus.

## Interface
- ADDRBITS, 26, Wishbone address width
- DATABITS, 16, Wishbone data width
- TIMEOUT_CYCLES, 255, max cycles a grant may wait for ack before forced error (≥2)

Ports:
- clk_i  in  1  system clock; one clock, all logic on rising edge
- reset_ni  in  1  asynchronous, active-low reset
- mN_cyc_i, mN_stb_i, mN_we_i  in  1 each  master N (N=0,1) cycle/strobe/write
- mN_adr_i  in  ADDRBITS  master N address
- mN_dat_i  in  DATABITS  master N write data
- mN_ack_o, mN_err_o, mN_stall_o  out  1 each  master N responses
- mN_dat_o  out  DATABITS  master N read data
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_adr_o  out  ADDRBITS; s_dat_o  out  DATABITS
- s_ack_i, s_err_i, s_stall_i  in  1 each; s_dat_i  in  DATABITS
- owner_o  out  2  one-hot current grant (00 = idle)
- timeout_o  out  1  one-cycle pulse on watchdog expiry

## Operation
- Request = mN_cyc_i. States: IDLE, GRANT0, GRANT1, RELEASE.
- IDLE: if exactly one request, grant it. If both, grant the master that was not last granted. last_grant resets to master 1, so master 0 wins the first tie. Transition at the next edge.
- GRANTn: the slave port is the owner's bus passed through combinationally. s_cyc_o = mn_cyc_i, s_stb_o = mn_stb_i, and we/adr/dat are passed likewise. mn_stall_o = s_stall_i. ack/err/dat route to the owner only.
- Non-owner: stall_o = 1, ack_o = 0, err_o = 0, dat_o = 0. In IDLE and RELEASE, both masters see stall = 1. In those states s_cyc_o = s_stb_o = 0 and s_we_o/adr/dat = 0.
- Owner drops cyc: go to IDLE next edge. last_grant = owner. Any outstanding slave ack is discarded.
- Watchdog counter: cleared on grant and on every s_ack_i or s_err_i. Otherwise it increments each GRANT cycle.
- When the counter reaches TIMEOUT_CYCLES-1 with no ack/err that cycle: next edge enters RELEASE. In that RELEASE-entry cycle, mn_err_o = 1 for exactly one cycle and timeout_o = 1.
- RELEASE: s_cyc_o = 0. Wait for the former owner's cyc_i = 0, then go to IDLE. A late s_ack_i in RELEASE is dropped.
- Counter width is $clog2(TIMEOUT_CYCLES+1), saturating, no wrap.

## Timing
- Grant latency: request at cycle N in IDLE → owner stall low and pass-through active at N+1.
- Back-to-back: owner release at N → IDLE at N+1 → the other master is granted at N+2. A queued request wins by round-robin.
- Ack/err and read data to the owner are combinational: zero added latency.
- Simultaneous s_ack_i and watchdog expiry: the ack wins, the counter clears, and there is no timeout.
- Simultaneous owner cyc drop and expiry: release wins, with no err/timeout pulse.
- Reset (async assert, any state): state IDLE, owner_o = 00, all s_* outputs 0, all mN_ack_o/err_o/dat_o 0, all mN_stall_o 1, timeout_o 0, counter 0, last_grant = 1.
- Reset deassertion must be synchronized externally.

## Structure
- Shared package/header (alongside cmd_defs.vh): arbiter state encodings ARB_IDLE/ARB_GRANT0/ARB_GRANT1/ARB_RELEASE (2-bit) and the default TIMEOUT_CYCLES.
- One sub-module: wb_watchdog, a counter with clear, enable and expire outputs, parameterized by TIMEOUT_CYCLES.
- Output muxing stays in the top module.

## Test plan
- Single master 0 read at adr 0x123456: slave acks after 3 cycles with 0xBEEF. Expect m0_dat_o = 0xBEEF with ack, m1_stall_o = 1 throughout, and owner_o 01 → 00 after m0 drops cyc.
- Both request in the same cycle after reset: master 0 is granted first. Master 1 is granted 2 cycles after master 0 drops cyc. A second simultaneous request grants master 1 first.
- Master 1 write 0x00F0 while master 0 requests mid-cycle: master 0 stalls until master 1 completes. Check s_we_o = 1, s_dat_o = 0x00F0, and that the stall never glitches low.
- Slave never acks with TIMEOUT_CYCLES = 8: exactly one m0_err_o/timeout_o pulse on the 8th grant cycle and s_cyc_o low in RELEASE. A late ack is not forwarded. IDLE follows the m0 cyc drop.
- s_ack_i coincident with the expiry cycle: ack delivered, no err, no timeout.
- reset_ni asserted asynchronously in GRANT1 mid-transfer: outputs take reset values immediately, without waiting for a clock edge.
